fb_scanout_reader: RTL and testbench

//  Read-side master for the fractal frame buffer RAM. On start it issues one linear

---
 rtl/fb_scanout_reader.sv | 136 +++++++++++++
 tb/tb_fb_scanout_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fb_scanout_reader.sv
// Frame-buffer scanout master: linear RAM reads, 2-cycle latency absorbed by a
// credit-limited show-ahead FIFO, pixels streamed out with x/y/sof/eol tags.
module fb_scanout_reader #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int DATA_SIZE  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        rd_en,
  output logic [18:0]                 rd_addr,
  input  logic signed [DATA_SIZE-1:0] rd_data,
  output logic signed [DATA_SIZE-1:0] pix_data,
  output logic [9:0]                  pix_x,
  output logic [9:0]                  pix_y,
  output logic                        pix_sof,
  output logic                        pix_eol,
  output logic                        pix_valid,
  input  logic                        pix_ready
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1) + 1;

  if (FIFO_DEPTH < 4) begin : g_depth_chk
    $error("fb_scanout_reader: FIFO_DEPTH must be >= 4");
  end
  if (NPIX > (1 << 19)) begin : g_size_chk
    $error("fb_scanout_reader: WIDTH*HEIGHT must fit in 19 address bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                      r_state, w_next;
  logic [2:1]                  r_vld_pipe;
  logic [18:0]                 r_addr;
  logic [CW-1:0]               r_count;
  logic [CW-1:0]               w_used;
  logic [PW-1:0]               r_wptr, r_rptr;
  logic signed [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [9:0]                  r_x, r_y;
  logic                        r_done;
  logic                        w_push, w_pop, w_last_addr, w_enter_idle;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits: FIFO occupancy plus reads still in the RAM pipe never exceed depth,
  // so a returning read always has a slot.
  assign w_used      = r_count + CW'(r_vld_pipe[1]) + CW'(r_vld_pipe[2]);
  assign rd_en       = (r_state == S_FETCH) && (w_used < CW'(FIFO_DEPTH));
  assign rd_addr     = r_addr;
  assign w_last_addr = (r_addr == 19'(NPIX - 1));
  assign w_push      = r_vld_pipe[2];
  assign pix_valid   = (r_count != '0);
  assign w_pop       = pix_valid & pix_ready;
  assign pix_data    = r_mem[r_rptr];
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign pix_sof     = pix_valid && (r_x == '0) && (r_y == '0);
  assign pix_eol     = pix_valid && (r_x == 10'(WIDTH - 1));
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (rd_en && w_last_addr) w_next = S_DRAIN;
      S_DRAIN: begin
        // Leave on the edge that pops the final pixel.
        if (r_vld_pipe == '0 &&
            (r_count == '0 || (r_count == CW'(1) && w_pop)))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_idle = (r_state != S_IDLE) && (w_next == S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_vld_pipe <= '0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_enter_idle;
      r_vld_pipe <= {r_vld_pipe[1], rd_en};
      if (w_enter_idle) r_addr <= '0;
      else if (rd_en)   r_addr <= r_addr + 19'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= rd_data;
        r_wptr        <= f_inc(r_wptr);
      end
      if (w_pop) r_rptr <= f_inc(r_rptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_enter_idle) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pop) begin
      if (r_x == 10'(WIDTH - 1)) begin
        r_x <= '0;
        r_y <= r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader on a 4x3 frame with a 2-cycle RAM model.
module tb_fb_scanout_reader;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int DS   = 4;
  localparam int FD   = 4;
  localparam int NPIX = W * H;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic                 pix_ready = 1'b0;
  logic                 busy, frame_done, rd_en;
  logic [18:0]          rd_addr;
  logic signed [DS-1:0] rd_data;
  logic signed [DS-1:0] pix_data;
  logic [9:0]           pix_x, pix_y;
  logic                 pix_sof, pix_eol, pix_valid;

  logic signed [DS-1:0] ram [16];
  logic signed [DS-1:0] ram_s1;

  int checks = 0;
  int errors = 0;
  int idx, nrd;

  fb_scanout_reader #(.WIDTH(W), .HEIGHT(H), .DATA_SIZE(DS), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy),
    .frame_done(frame_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 clock = ~clock;

  // Registered read port, data two cycles after rd_en; X when no read was issued.
  always @(posedge clock) begin
    ram_s1  <= (rd_en && rd_addr < 19'(NPIX)) ? ram[rd_addr[3:0]] : 'x;
    rd_data <= ram_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // rmode: 0 ready held high, 1 stalled for 20 cycles, 2 random ready.
  // stop_at >= 0 returns while pixel stop_at is presented (frame left running).
  task automatic do_frame(input int rmode, input bit repulse, input int stop_at);
    bit seen_valid = 1'b0;
    bit done = 1'b0;
    idx = 0;
    nrd = 0;
    start = 1'b1;
    pix_ready = (rmode == 0);
    step();
    start = 1'b0;
    for (int c = 1; c < 300 && !done; c++) begin
      logic [DS-1:0] e;
      case (rmode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (c > 20);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      start = repulse && (c == 5 || c == 10);
      #1;
      if (c == 1) chk("busy_c1", busy, 1);
      if (rd_en) nrd++;
      if (rmode == 1 && c == 20) begin
        chk("stall_reads", nrd, FD);
        chk("stall_addr", rd_addr, 4);
        chk("stall_valid", pix_valid, 1);
      end
      if (pix_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (rmode == 0) chk("first_valid_cycle", c, 4);
      end
      if (stop_at >= 0 && idx == stop_at && pix_valid) return;
      if (pix_valid) begin
        e = DS'(idx);
        chk("pix_data", {28'd0, pix_data}, {28'd0, e});
        chk("pix_x", pix_x, idx % W);
        chk("pix_y", pix_y, idx / W);
        chk("pix_sof", pix_sof, idx == 0);
        chk("pix_eol", pix_eol, (idx % W) == W - 1);
        if (pix_ready) idx++;
      end
      if (frame_done) begin
        chk("pixels_at_done", idx, NPIX);
        chk("busy_at_done", busy, 0);
        done = 1'b1;
      end
      if (!done) step();
    end
    start = 1'b0;
    chk("frame_done_seen", done, 1);
    chk("rd_en_cycles", nrd, NPIX);
    step();
    #1;
    chk("done_single_pulse", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_x", pix_x, 0);
    chk("idle_y", pix_y, 0);
    chk("idle_addr", rd_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = DS'(i);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    reset_n = 1'b1;
    step();

    do_frame(0, 1'b0, -1);   // nominal latency and ordering
    do_frame(1, 1'b0, -1);   // long downstream stall
    do_frame(2, 1'b0, -1);   // random backpressure
    do_frame(0, 1'b1, -1);   // start re-pulsed mid-frame

    // Reset mid-frame with reads in flight.
    do_frame(0, 1'b0, 6);
    reset_n = 1'b0;
    #1;
    chk("abort_rd_en", rd_en, 0);
    chk("abort_addr", rd_addr, 0);
    chk("abort_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_x", pix_x, 0);
    chk("abort_y", pix_y, 0);
    chk("abort_data", {28'd0, pix_data}, 0);
    pix_ready = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    do_frame(0, 1'b0, -1);   // clean frame after reset
    do_frame(0, 1'b0, -1);   // back-to-back with the previous frame

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
